// File: rtl/dispatch_queue_pkg.sv
// Shared types for the dispatch queue: decoder op classes, default depth and routing helper.
package dispatch_queue_pkg;

  localparam int unsigned DqDepth = 32;

  typedef enum logic [2:0] {
    OpRType     = 3'd0,
    OpIType     = 3'd1,
    OpILoadType = 3'd2,
    OpSType     = 3'd3,
    OpBType     = 3'd4,
    OpUType     = 3'd5,
    OpJType     = 3'd6,
    OpJalrType  = 3'd7
  } op_type_e;

  // Loads and stores go to the LSB; every other class goes to the RS.
  function automatic logic is_lsb_class(op_type_e op);
    return (op == OpSType) || (op == OpILoadType);
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Handshake bundle between fetch/decode, the dispatch queue and the ROB/RS/LSB back end.
interface dispatch_queue_if
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            rdy_in;
  logic            roll_back;
  logic            instruction_ready;
  logic [XLEN-1:0] instruction_in;
  logic [XLEN-1:0] pc_in;
  op_type_e        op_type_in;
  logic            rob_is_full;
  logic            rs_is_full;
  logic            lsb_is_full;
  logic            ins_to_rob;
  logic            ins_to_rs;
  logic            ins_to_lsb;
  logic [XLEN-1:0] instruction_out;
  logic [XLEN-1:0] ins_pc_out;
  logic [AW:0]     count;
  logic            is_full;
  logic            almost_full;

  modport master (
    output rdy_in, roll_back, instruction_ready, instruction_in, pc_in, op_type_in,
           rob_is_full, rs_is_full, lsb_is_full,
    input  ins_to_rob, ins_to_rs, ins_to_lsb, instruction_out, ins_pc_out,
           count, is_full, almost_full
  );

  modport slave (
    input  rdy_in, roll_back, instruction_ready, instruction_in, pc_in, op_type_in,
           rob_is_full, rs_is_full, lsb_is_full,
    output ins_to_rob, ins_to_rs, ins_to_lsb, instruction_out, ins_pc_out,
           count, is_full, almost_full
  );
endinterface

// File: rtl/dispatch_queue_route.sv
// Combinational issue decision for the head entry: can it go, and to RS or LSB.
module dispatch_queue_route
  import dispatch_queue_pkg::*;
(
  input  logic     valid_i,
  input  op_type_e op_type_i,
  input  logic     rob_full_i,
  input  logic     rs_full_i,
  input  logic     lsb_full_i,
  output logic     issue_o,
  output logic     to_rs_o,
  output logic     to_lsb_o
);
  logic lsb_class;

  always_comb begin
    lsb_class = is_lsb_class(op_type_i);
    issue_o   = valid_i && !rob_full_i && (lsb_class ? !lsb_full_i : !rs_full_i);
    to_lsb_o  = issue_o && lsb_class;
    to_rs_o   = issue_o && !lsb_class;
  end
endmodule

// File: rtl/dispatch_queue.sv
// In-order instruction queue: buffers decoded instructions and issues one per cycle to ROB+RS/LSB.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = DqDepth,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter int unsigned AF_MARGIN = 2,
  parameter int unsigned XLEN      = 32
) (
  input logic             clk_in,
  input logic             rst_in,
  dispatch_queue_if.slave dq
);
  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);
  localparam logic [AW:0] AfLevel   = (AW+1)'(DEPTH - AF_MARGIN);

  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  op_type_e        op_mem   [DEPTH];

  logic [AW-1:0]   head_q, head_d, rear_q, rear_d;
  logic [AW:0]     count_q, count_d;
  logic            rob_q, rob_d, rs_q, rs_d, lsb_q, lsb_d;
  logic [XLEN-1:0] inst_out_q, inst_out_d, pc_out_q, pc_out_d;

  logic full, enq, issue, to_rs, to_lsb, mem_we;

  assign full = (count_q == FullLevel);
  assign enq  = dq.instruction_ready && !full;

  dispatch_queue_route u_route (
    .valid_i   (count_q != '0),
    .op_type_i (op_mem[head_q]),
    .rob_full_i(dq.rob_is_full),
    .rs_full_i (dq.rs_is_full),
    .lsb_full_i(dq.lsb_is_full),
    .issue_o   (issue),
    .to_rs_o   (to_rs),
    .to_lsb_o  (to_lsb)
  );

  always_comb begin
    head_d     = head_q;
    rear_d     = rear_q;
    count_d    = count_q;
    rob_d      = 1'b0;
    rs_d       = 1'b0;
    lsb_d      = 1'b0;
    inst_out_d = inst_out_q;
    pc_out_d   = pc_out_q;
    if (dq.roll_back) begin
      head_d     = '0;
      rear_d     = '0;
      count_d    = '0;
      inst_out_d = '0;
      pc_out_d   = '0;
    end else begin
      if (enq) rear_d = rear_q + 1'b1;
      if (issue) begin
        head_d     = head_q + 1'b1;
        rob_d      = 1'b1;
        rs_d       = to_rs;
        lsb_d      = to_lsb;
        inst_out_d = inst_mem[head_q];
        pc_out_d   = pc_mem[head_q];
      end
      case ({enq, issue})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q     <= '0;
      rear_q     <= '0;
      count_q    <= '0;
      rob_q      <= 1'b0;
      rs_q       <= 1'b0;
      lsb_q      <= 1'b0;
      inst_out_q <= '0;
      pc_out_q   <= '0;
    end else if (dq.rdy_in) begin
      head_q     <= head_d;
      rear_q     <= rear_d;
      count_q    <= count_d;
      rob_q      <= rob_d;
      rs_q       <= rs_d;
      lsb_q      <= lsb_d;
      inst_out_q <= inst_out_d;
      pc_out_q   <= pc_out_d;
    end
  end

  // Storage carries no reset; occupancy alone decides which slots are meaningful.
  assign mem_we = !rst_in && dq.rdy_in && !dq.roll_back && enq;

  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      inst_mem[rear_q] <= dq.instruction_in;
      pc_mem[rear_q]   <= dq.pc_in;
      op_mem[rear_q]   <= dq.op_type_in;
    end
  end

  assign dq.ins_to_rob      = rob_q;
  assign dq.ins_to_rs       = rs_q;
  assign dq.ins_to_lsb      = lsb_q;
  assign dq.instruction_out = inst_out_q;
  assign dq.ins_pc_out      = pc_out_q;
  assign dq.count           = count_q;
  assign dq.is_full         = full;
  assign dq.almost_full     = (count_q >= AfLevel);
endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue: queue-based reference model, directed phases, random traffic.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned AW        = 3;
  localparam int unsigned AF_MARGIN = 2;
  localparam int unsigned XLEN      = 32;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    op_type_e    op;
  } entry_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        lsb;
    int unsigned edge_no;
  } issue_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispatch_queue_if #(.XLEN(XLEN), .AW(AW)) dq ();

  dispatch_queue #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .AF_MARGIN(AF_MARGIN),
    .XLEN     (XLEN)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .dq    (dq)
  );

  entry_t      mq[$];
  issue_t      sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned edge_cnt = 0;
  logic        edge_live = 1'b0;
  logic        mon_en = 1'b0;
  logic [31:0] m_out_inst = '0;
  logic [31:0] m_out_pc = '0;
  logic [31:0] pc_next = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic lsb_op(op_type_e op);
    return (op == OpILoadType) || (op == OpSType);
  endfunction

  // Reference behaviour of one clock edge, using the inputs that were present at that edge.
  task automatic model_edge();
    entry_t e;
    issue_t r;
    logic   iss, enq, lsb;
    edge_cnt++;
    edge_live = rst || dq.rdy_in;
    mon_en    = 1'b1;
    if (rst || (dq.rdy_in && dq.roll_back)) begin
      mq.delete();
      m_out_inst = '0;
      m_out_pc   = '0;
    end else if (dq.rdy_in) begin
      iss = 1'b0;
      lsb = 1'b0;
      if (mq.size() != 0) begin
        lsb = lsb_op(mq[0].op);
        iss = !dq.rob_is_full && (lsb ? !dq.lsb_is_full : !dq.rs_is_full);
      end
      enq = dq.instruction_ready && (mq.size() < int'(DEPTH));
      if (iss) begin
        e = mq.pop_front();
        r.inst = e.inst;
        r.pc = e.pc;
        r.lsb = lsb;
        r.edge_no = edge_cnt;
        sb.push_back(r);
        m_out_inst = e.inst;
        m_out_pc   = e.pc;
      end
      if (enq) begin
        e.inst = dq.instruction_in;
        e.pc   = dq.pc_in;
        e.op   = dq.op_type_in;
        mq.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic defaults();
    dq.rdy_in            = 1'b1;
    dq.roll_back         = 1'b0;
    dq.instruction_ready = 1'b0;
    dq.instruction_in    = '0;
    dq.pc_in             = '0;
    dq.op_type_in        = OpRType;
    dq.rob_is_full       = 1'b0;
    dq.rs_is_full        = 1'b0;
    dq.lsb_is_full       = 1'b0;
  endtask

  task automatic present(input logic valid, input op_type_e op);
    dq.instruction_ready = valid;
    dq.instruction_in    = $urandom;
    dq.pc_in             = pc_next;
    dq.op_type_in        = op;
    if (valid) pc_next = pc_next + 32'd4;
  endtask

  // Monitor: checks occupancy flags every cycle and pops the scoreboard on each issue strobe.
  initial begin
    logic [2:0] prev_strobes;
    logic [2:0] strobes;
    logic       exp_here;
    issue_t     rec;
    prev_strobes = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        strobes = {dq.ins_to_rob, dq.ins_to_rs, dq.ins_to_lsb};
        chk("count", 64'(dq.count), 64'(mq.size()));
        chk("is_full", 64'(dq.is_full), 64'(mq.size() == int'(DEPTH)));
        chk("almost_full", 64'(dq.almost_full), 64'(mq.size() >= int'(DEPTH - AF_MARGIN)));
        if (edge_live) begin
          exp_here = (sb.size() != 0) && (sb[0].edge_no == edge_cnt);
          chk("strobe_present", 64'(strobes != 3'b000), 64'(exp_here));
          if (exp_here) begin
            rec = sb.pop_front();
            if (strobes != 3'b000) begin
              chk("strobe_route", 64'(strobes), 64'({1'b1, !rec.lsb, rec.lsb}));
              chk("issue_inst", 64'(dq.instruction_out), 64'(rec.inst));
              chk("issue_pc", 64'(dq.ins_pc_out), 64'(rec.pc));
            end
          end
        end else begin
          chk("frozen_strobes", 64'(strobes), 64'(prev_strobes));
        end
        chk("held_inst", 64'(dq.instruction_out), 64'(m_out_inst));
        chk("held_pc", 64'(dq.ins_pc_out), 64'(m_out_pc));
        prev_strobes = strobes;
      end
    end
  end

  initial begin
    defaults();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Three ALU ops with nothing blocked.
    for (int i = 0; i < 3; i++) begin
      present(1'b1, OpRType);
      step();
    end
    present(1'b0, OpRType);
    repeat (5) step();

    // Load then store held back by a full LSB, then released.
    dq.lsb_is_full = 1'b1;
    present(1'b1, OpILoadType);
    step();
    present(1'b1, OpSType);
    step();
    present(1'b0, OpRType);
    repeat (4) step();
    dq.lsb_is_full = 1'b0;
    repeat (4) step();

    // Fill to DEPTH with issue blocked; the extra word must be dropped.
    dq.rob_is_full = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 1; i++) begin
      present(1'b1, op_type_e'($urandom_range(0, 7)));
      step();
    end
    present(1'b0, OpRType);
    step();
    dq.rob_is_full = 1'b0;
    repeat (DEPTH + 3) step();

    // Twenty back-to-back enqueue/issue pairs wrapping the pointers.
    pc_next = '0;
    for (int i = 0; i < 20; i++) begin
      present(1'b1, op_type_e'($urandom_range(0, 7)));
      step();
    end
    present(1'b0, OpRType);
    repeat (4) step();

    // Roll back while an issue strobe is showing and five entries remain.
    dq.rob_is_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      present(1'b1, OpRType);
      step();
    end
    present(1'b0, OpRType);
    dq.rob_is_full = 1'b0;
    step();
    dq.roll_back = 1'b1;
    step();
    dq.roll_back = 1'b0;
    repeat (4) step();

    // Pause for three cycles in the middle of a stream.
    for (int i = 0; i < 10; i++) begin
      present(1'b1, op_type_e'($urandom_range(0, 7)));
      dq.rdy_in = !(i >= 4 && i < 7);
      step();
    end
    dq.rdy_in = 1'b1;
    present(1'b0, OpRType);
    repeat (DEPTH + 2) step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      dq.rdy_in      = ($urandom_range(0, 9) != 0);
      dq.roll_back   = ($urandom_range(0, 63) == 0);
      dq.rob_is_full = ($urandom_range(0, 3) == 0);
      dq.rs_is_full  = ($urandom_range(0, 3) == 0);
      dq.lsb_is_full = ($urandom_range(0, 3) == 0);
      present(($urandom_range(0, 2) != 0), op_type_e'($urandom_range(0, 7)));
      step();
    end

    defaults();
    repeat (2 * DEPTH + 4) step();
    @(negedge clk);
    chk("drained_count", 64'(dq.count), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
